// File: rtl/si5340_cfg_ctrl.sv
// si5340_cfg_ctrl: loads the Si5340 config ROM as paged I2C byte writes with pause, retry and done/error reporting
module si5340_cfg_ctrl #(
  parameter int         WORD_NUMBER    = 326,
  parameter int         PREAMBLE_WORDS = 3,
  parameter int         PAUSE_CYCLES   = 37_500_000,
  parameter logic [6:0] SLAVE_ADDR     = 7'h74,
  parameter int         MAX_RETRY      = 3
) (
  input  logic                           clk_i,
  input  logic                           rstn_i,
  input  logic                           start_i,
  output logic [$clog2(WORD_NUMBER)-1:0] rom_addr_o,
  input  logic [23:0]                    rom_data_i,
  output logic                           cmd_valid_o,
  input  logic                           cmd_ready_i,
  output logic                           cmd_start_o,
  output logic                           cmd_stop_o,
  output logic [7:0]                     cmd_data_o,
  input  logic                           rsp_valid_i,
  input  logic                           rsp_nack_i,
  output logic                           busy_o,
  output logic                           done_o,
  output logic                           error_o
);
  localparam int AW = $clog2(WORD_NUMBER);
  localparam int PW = (PAUSE_CYCLES > 0) ? $clog2(PAUSE_CYCLES + 1) : 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] FETCH    = 4'd1;
  localparam logic [3:0] LATCH    = 4'd2;
  localparam logic [3:0] PAGE_TX  = 4'd3;
  localparam logic [3:0] REG_TX   = 4'd4;
  localparam logic [3:0] WAIT_RSP = 4'd5;
  localparam logic [3:0] PAUSE    = 4'd6;
  localparam logic [3:0] NEXT     = 4'd7;
  localparam logic [3:0] DONE     = 4'd8;
  localparam logic [3:0] ERROR    = 4'd9;
  logic [3:0]    state;
  logic [AW-1:0] idx;
  logic [23:0]   word;
  logic [7:0]    cur_page;
  logic          page_valid;
  logic          is_page;
  logic [1:0]    bcnt;
  logic [RW-1:0] retry;
  logic [PW-1:0] pcnt;
  logic          tx;
  logic          last;
  logic          pre_end;
  logic          new_page;
  logic [7:0]    tx_byte;
  assign tx          = (state == PAGE_TX) || (state == REG_TX);
  assign last        = idx == AW'(WORD_NUMBER - 1);
  assign pre_end     = idx == AW'(PREAMBLE_WORDS - 1);
  assign new_page    = !page_valid || (rom_data_i[23:16] != cur_page);
  assign rom_addr_o  = idx;
  assign cmd_valid_o = tx;
  assign cmd_start_o = tx && (bcnt == 2'd0);
  assign cmd_stop_o  = tx && (bcnt == 2'd2);
  assign cmd_data_o  = tx ? tx_byte : 8'h00;
  // byte of the current transaction: device address, then register, then value
  always_comb
    tx_byte = (bcnt == 2'd0) ? {SLAVE_ADDR, 1'b0} :
              (bcnt == 2'd1) ? (is_page ? 8'h01 : word[15:8]) :
                               (is_page ? word[23:16] : word[7:0]);
  // load sequencer: fetch word, optional page write, register write, pause after preamble
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state      <= IDLE;
      idx        <= '0;
      word       <= '0;
      cur_page   <= '0;
      page_valid <= 1'b0;
      is_page    <= 1'b0;
      bcnt       <= '0;
      retry      <= '0;
      pcnt       <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      error_o    <= 1'b0;
    end else begin
      pcnt <= (state == PAUSE) ? pcnt + 1'b1 : '0;
      case (state)
        IDLE, DONE, ERROR: if (start_i) begin
          state      <= FETCH;
          idx        <= '0;
          page_valid <= 1'b0;
          retry      <= '0;
          busy_o     <= 1'b1;
          done_o     <= 1'b0;
          error_o    <= 1'b0;
        end
        FETCH: state <= LATCH;
        LATCH: begin
          word    <= rom_data_i;
          bcnt    <= '0;
          is_page <= new_page;
          state   <= new_page ? PAGE_TX : REG_TX;
        end
        PAGE_TX, REG_TX: if (cmd_ready_i) state <= WAIT_RSP;
        WAIT_RSP: if (rsp_valid_i) begin
          if (rsp_nack_i) begin
            if (retry < RW'(MAX_RETRY)) begin
              retry <= retry + 1'b1;
              bcnt  <= '0;
              state <= is_page ? PAGE_TX : REG_TX;
            end else begin
              state      <= ERROR;
              page_valid <= 1'b0;
              busy_o     <= 1'b0;
              error_o    <= 1'b1;
            end
          end else if (bcnt != 2'd2) begin
            bcnt  <= bcnt + 1'b1;
            state <= is_page ? PAGE_TX : REG_TX;
          end else if (is_page) begin
            cur_page   <= word[23:16];
            page_valid <= 1'b1;
            retry      <= '0;
            is_page    <= 1'b0;
            bcnt       <= '0;
            state      <= REG_TX;
          end else begin
            retry <= '0;
            state <= NEXT;
          end
        end
        NEXT, PAUSE: begin
          if (state == NEXT && pre_end && PAUSE_CYCLES > 0) state <= PAUSE;
          else if (state == NEXT || pcnt == PW'(PAUSE_CYCLES - 1)) begin
            if (last) begin
              state  <= DONE;
              busy_o <= 1'b0;
              done_o <= 1'b1;
            end else begin
              idx   <= idx + 1'b1;
              state <= FETCH;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_si5340_cfg_ctrl.sv
// tb_si5340_cfg_ctrl: scoreboard bench with an I2C byte-master model and a 3-word config ROM
module tb_si5340_cfg_ctrl;
  typedef struct {
    logic [7:0] d;
    logic       s;
    logic       p;
    int         lat;
  } byte_t;
  logic        clk = 1'b0;
  logic        rstn_i = 1'b0;
  logic        start_i = 1'b0;
  logic [1:0]  rom_addr_o;
  logic [23:0] rom_data_i;
  logic        cmd_valid_o, cmd_ready_i, cmd_start_o, cmd_stop_o;
  logic [7:0]  cmd_data_o;
  logic        rsp_valid_i, rsp_nack_i;
  logic        busy_o, done_o, error_o;
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          last_rsp = 0;
  int          stall = 0;
  int          nack_cnt = 0;
  logic [7:0]  nack_d = 8'h00;
  logic        nack_s = 1'b0;
  logic        nack_p = 1'b0;
  byte_t       exp_q[$];
  byte_t       obs_q[$];

  si5340_cfg_ctrl #(
    .WORD_NUMBER(3), .PREAMBLE_WORDS(1), .PAUSE_CYCLES(10), .SLAVE_ADDR(7'h74), .MAX_RETRY(3)
  ) dut (
    .clk_i(clk), .rstn_i(rstn_i), .start_i(start_i), .rom_addr_o(rom_addr_o), .rom_data_i(rom_data_i),
    .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i), .cmd_start_o(cmd_start_o), .cmd_stop_o(cmd_stop_o),
    .cmd_data_o(cmd_data_o), .rsp_valid_i(rsp_valid_i), .rsp_nack_i(rsp_nack_i),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [23:0] rom_word(input logic [1:0] a);
    return (a == 2'd0) ? 24'h0B24C0 : (a == 2'd1) ? 24'h0B2502 : 24'h0C1D01;
  endfunction
  always @(posedge clk) rom_data_i <= rom_word(rom_addr_o);

  task automatic chk(input string nm, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic s, input logic p, input int lat);
    byte_t b;
    b.d = d; b.s = s; b.p = p; b.lat = lat;
    exp_q.push_back(b);
  endtask

  task automatic push_txn(input logic [7:0] b1, input logic [7:0] b2, input int lat0);
    push(8'hE8, 1'b1, 1'b0, lat0);
    push(b1, 1'b0, 1'b0, 1);
    push(b2, 1'b0, 1'b1, 1);
  endtask

  task automatic push_load();
    push_txn(8'h01, 8'h0B, -1);
    push_txn(8'h24, 8'hC0, 1);
    push_txn(8'h25, 8'h02, 14);
    push_txn(8'h01, 8'h0C, 4);
    push_txn(8'h1D, 8'h01, 1);
  endtask

  task automatic do_start();
    @(negedge clk); start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    chk("start_busy", busy_o, 1);
    chk("start_done_clr", done_o, 0);
    chk("start_err_clr", error_o, 0);
  endtask

  task automatic wait_end();
    int n = 0;
    while (!(done_o || error_o) && n < 3000) begin @(negedge clk); n++; end
    if (n >= 3000) chk("end_timeout", 1, 0);
    repeat (3) @(negedge clk);
    chk("leftover_expected", exp_q.size(), 0);
  endtask

  task automatic chk_idle_outputs(input string nm);
    chk({nm, "_busy"}, busy_o, 0);
    chk({nm, "_done"}, done_o, 0);
    chk({nm, "_error"}, error_o, 0);
    chk({nm, "_cmd"}, {cmd_valid_o, cmd_start_o, cmd_stop_o, cmd_data_o}, 0);
    chk({nm, "_rom_addr"}, rom_addr_o, 0);
  endtask

  // I2C byte-master model: optional ready stall, one response pulse per accepted byte
  initial begin
    byte_t snap;
    int ms = 0;
    int stall_left = 0;
    cmd_ready_i = 1'b0; rsp_valid_i = 1'b0; rsp_nack_i = 1'b0;
    forever begin
      @(negedge clk);
      rsp_valid_i = 1'b0; rsp_nack_i = 1'b0;
      if (!rstn_i) begin
        ms = 0; cmd_ready_i = 1'b0;
      end else if (ms == 0) begin
        if (cmd_valid_o) begin
          snap.d = cmd_data_o; snap.s = cmd_start_o; snap.p = cmd_stop_o; snap.lat = cyc - last_rsp;
          stall_left = stall;
          if (stall == 0) begin cmd_ready_i = 1'b1; ms = 2; end
          else ms = 1;
        end
      end else if (ms == 1) begin
        chk("hold_data", cmd_data_o, snap.d);
        chk("hold_flags", {cmd_valid_o, cmd_start_o, cmd_stop_o}, {1'b1, snap.s, snap.p});
        stall_left--;
        if (stall_left == 0) begin cmd_ready_i = 1'b1; ms = 2; end
      end else if (ms == 2) begin
        cmd_ready_i = 1'b0;
        obs_q.push_back(snap);
        ms = 3;
      end else begin
        rsp_valid_i = 1'b1;
        if (nack_cnt > 0 && snap.d == nack_d && snap.s == nack_s && snap.p == nack_p) begin
          rsp_nack_i = 1'b1;
          nack_cnt--;
        end
        last_rsp = cyc;
        ms = 0;
      end
    end
  end

  // scoreboard monitor: pairs every accepted byte with the next expected one
  initial begin
    byte_t o, e;
    forever begin
      @(negedge clk);
      while (obs_q.size() > 0) begin
        o = obs_q.pop_front();
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_byte: got %0h expected none", o.d);
        end else begin
          e = exp_q.pop_front();
          chk("byte_data", o.d, e.d);
          chk("byte_flags", {o.s, o.p}, {e.s, e.p});
          if (e.lat >= 0) chk("byte_gap", o.lat, e.lat);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    rstn_i = 1'b1;
    // 1: plain load with page skip and post-preamble pause
    push_load(); do_start(); wait_end();
    chk("t1_done", done_o, 1); chk("t1_busy", busy_o, 0); chk("t1_err", error_o, 0);
    // 2: master stalls ready for 5 cycles on every byte
    stall = 5;
    push_load(); do_start(); wait_end();
    chk("t2_done", done_o, 1); chk("t2_busy", busy_o, 0);
    stall = 0;
    // 3: first two address bytes NACKed, third attempt succeeds
    nack_d = 8'hE8; nack_s = 1'b1; nack_p = 1'b0; nack_cnt = 2;
    push(8'hE8, 1'b1, 1'b0, -1);
    push(8'hE8, 1'b1, 1'b0, 1);
    push_txn(8'h01, 8'h0B, 1);
    push_txn(8'h24, 8'hC0, 1);
    push_txn(8'h25, 8'h02, 14);
    push_txn(8'h01, 8'h0C, 4);
    push_txn(8'h1D, 8'h01, 1);
    do_start(); wait_end();
    chk("t3_done", done_o, 1); chk("t3_err", error_o, 0); chk("t3_nacks_used", nack_cnt, 0);
    // 4: data byte of first register write always NACKed -> error after 4 attempts
    nack_d = 8'hC0; nack_s = 1'b0; nack_p = 1'b1; nack_cnt = 100;
    push_txn(8'h01, 8'h0B, -1);
    repeat (4) push_txn(8'h24, 8'hC0, 1);
    do_start(); wait_end();
    chk("t4_err", error_o, 1); chk("t4_done", done_o, 0); chk("t4_busy", busy_o, 0);
    chk("t4_cmd_idle", cmd_valid_o, 0); chk("t4_attempts", 100 - nack_cnt, 4);
    nack_cnt = 0;
    push_load(); do_start(); wait_end();
    chk("t4_reload_done", done_o, 1); chk("t4_reload_err", error_o, 0);
    // 5: reset during the pause, then reload from word 0
    push_txn(8'h01, 8'h0B, -1);
    push_txn(8'h24, 8'hC0, 1);
    do_start();
    n = 0;
    while (exp_q.size() > 0 && n < 3000) begin @(negedge clk); n++; end
    if (n >= 3000) chk("t5_timeout", 1, 0);
    repeat (5) @(negedge clk);
    chk("t5_busy_in_pause", busy_o, 1);
    rstn_i = 1'b0;
    @(negedge clk);
    chk_idle_outputs("t5_reset");
    @(negedge clk);
    rstn_i = 1'b1;
    repeat (20) @(negedge clk);
    chk("t5_no_stray_bytes", obs_q.size() + exp_q.size(), 0);
    chk("t5_idle_after_reset", {busy_o, done_o, error_o}, 0);
    push_load(); do_start(); wait_end();
    chk("t5_done", done_o, 1);
    // 6: start pulsed mid-load is ignored
    push_load(); do_start();
    n = 0;
    while (exp_q.size() > 8 && n < 3000) begin @(negedge clk); n++; end
    if (n >= 3000) chk("t6_timeout", 1, 0);
    chk("t6_busy_at_pulse", busy_o, 1);
    start_i = 1'b1; @(negedge clk); start_i = 1'b0;
    wait_end();
    chk("t6_done", done_o, 1); chk("t6_err", error_o, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/si5340_cfg_ctrl.md
Name: si5340_cfg_ctrl

Overview:
Sequences the full Si5340 configuration load over a shared byte-level I2C master. Fetches 24-bit {addr[15:0], data[7:0]} words from the config ROM and converts each into page-select and register-write I2C transactions, skipping page writes when the page is unchanged. Inserts the mandatory post-preamble calibration pause, retries NACKed transactions, and reports done/error to the board-level reset/bring-up logic.

Parameters:
WORD_NUMBER, 326, number of config words in ROM
PREAMBLE_WORDS, 3, words forming the preamble; the pause follows word PREAMBLE_WORDS-1
PAUSE_CYCLES, 37_500_000, post-preamble wait in clk_i cycles (300 ms at 125 MHz)
SLAVE_ADDR, 7'h74, 7-bit device address; address byte sent = {SLAVE_ADDR,1'b0}
MAX_RETRY, 3, retries per transaction after the first NACK

Ports:
clk_i  in  1  system clock
rstn_i  in  1  synchronous active-low reset
start_i  in  1  single-cycle load request
rom_addr_o  out  $clog2(WORD_NUMBER)  config ROM word index
rom_data_i  in  24  ROM word; valid 1 cycle after rom_addr_o changes
cmd_valid_o  out  1  byte command valid to I2C master
cmd_ready_i  in  1  I2C master accepts command
cmd_start_o  out  1  generate START before this byte
cmd_stop_o  out  1  generate STOP after this byte
cmd_data_o  out  8  byte to transmit
rsp_valid_i  in  1  byte completed (1-cycle pulse)
rsp_nack_i  in  1  slave NACKed; qualified by rsp_valid_i; master issues STOP itself
busy_o  out  1  load in progress
done_o  out  1  load completed; level
error_o  out  1  retries exhausted; level

Behaviour:
- One clock, synchronous active-low reset. Reset values: all outputs 0; page_valid cleared; retry counter 0; state IDLE. Reset mid-transaction abandons it immediately (cmd_valid_o drops in the cycle after reset is sampled).
- States: IDLE, FETCH, LATCH, PAGE_TX, REG_TX, WAIT_RSP, PAUSE, NEXT, DONE, ERROR.
- IDLE/DONE/ERROR: start_i -> FETCH, word index 0, done_o/error_o cleared, page_valid cleared, busy_o=1. start_i ignored in all other states.
- FETCH: rom_addr_o = index; wait 1 cycle. LATCH: capture rom_data_i. If !page_valid or addr[15:8] != cur_page -> PAGE_TX, else REG_TX.
- Transaction = 3 bytes: b0 {SLAVE_ADDR,0} with cmd_start_o=1; b1 register (PAGE_TX: 8'h01; REG_TX: addr[7:0]); b2 (PAGE_TX: addr[15:8]; REG_TX: data) with cmd_stop_o=1.
- Handshake: cmd_valid_o and cmd_*_o are held stable until cmd_valid_o & cmd_ready_i; then cmd_valid_o=0 and WAIT_RSP until rsp_valid_i. At most one byte outstanding.
- ACK on b2 of PAGE_TX: cur_page updated, page_valid=1, retry counter cleared -> REG_TX. ACK on b2 of REG_TX -> retry counter cleared, NEXT.
- NACK on any byte: abort the transaction; if retries < MAX_RETRY, increment and restart the same transaction at b0; otherwise -> ERROR (busy_o=0, error_o=1, page_valid cleared).
- NEXT: if index == PREAMBLE_WORDS-1 -> PAUSE; else if index == WORD_NUMBER-1 -> DONE (busy_o=0, done_o=1); else index+1 -> FETCH.
- PAUSE: count PAUSE_CYCLES cycles exactly, then index+1 -> FETCH (or DONE if it is the last word). PAUSE_CYCLES=0 skips the pause.
- rsp_valid_i outside WAIT_RSP is ignored. Counters sized by $clog2 of their limit+1; no wrap beyond the limit.

Test Plan:
1. WORD_NUMBER=3, PREAMBLE_WORDS=1, PAUSE_CYCLES=10, ROM {0x0B24C0, 0x0B2502, 0x0C1D01}, always-ACK master -> bytes E8,01,0B | E8,24,C0 | (10-cycle gap) E8,25,02 | E8,01,0C | E8,1D,01; START only on E8, STOP only on 3rd bytes; done_o=1, busy_o=0.
2. Same ROM, cmd_ready_i low 5 cycles per byte -> cmd_data_o/flags stable while cmd_valid_o=1; byte stream identical to test 1.
3. NACK on the first E8 twice, MAX_RETRY=3 -> the page transaction is sent 3 times; load completes with done_o=1, error_o=0.
4. Permanent NACK on the REG_TX data byte -> exactly 1+MAX_RETRY attempts; error_o=1, done_o=0, busy_o=0; a fresh start_i restarts at word 0 with a page write.
5. rstn_i low during PAUSE, then start_i -> all outputs 0 after reset; reload starts from index 0 with the page write re-issued.
6. start_i pulsed while busy_o=1 -> ignored; byte stream unchanged.
